wb_burst_sram: RTL and testbench

Parametrised Wishbone B4 registered-feedback SRAM slave, successor to the classic-cycle SRAM under the burst benchmark. It supports classic, constant-address and incrementing bursts with linear or wrap-4/8/16 addressing. The slave prefetches the predicted next address so that a burst sustains one beat per clock after a single wait state. It is the device under test behind the benchmark bench, driven directly by the burst-capable master model.

---
 rtl/wb_burst_pkg.sv | 21 ++
 rtl/sram_1rw_be.sv | 26 ++
 rtl/wb_burst_sram.sv | 75 +++++++
 tb/tb_wb_burst_sram.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/wb_burst_pkg.sv
// wb_burst_pkg: Wishbone B4 cycle/burst type constants and burst address prediction
package wb_burst_pkg;
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   // Address of the beat after adr; callers truncate to their bus width, which
   // makes the linear case wrap modulo 2^ADDR_WIDTH.
   function automatic logic [63:0] next_adr(input logic [63:0] adr, input logic [2:0] cti,
                                            input logic [1:0] bte);
      return cti == CTI_CONST ? adr :
             bte == BTE_WRAP4 ? {adr[63:2], adr[1:0] + 2'd1} :
             bte == BTE_WRAP8 ? {adr[63:3], adr[2:0] + 3'd1} :
             bte == BTE_WRAP16 ? {adr[63:4], adr[3:0] + 4'd1} : adr + 64'd1;
   endfunction
endpackage

// File: rtl/sram_1rw_be.sv
// sram_1rw_be: single-port synchronous RAM with byte-enable writes and a registered read port
//   i_clk clock; i_en port enable; i_we write (else read); i_sel byte enables;
//   i_adr word address; i_dat write data; o_dat read data, one cycle after a read
module sram_1rw_be #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                    i_clk,
   input  logic                    i_en,
   input  logic                    i_we,
   input  logic [DATA_WIDTH/8-1:0] i_sel,
   input  logic [DEPTH_LOG2-1:0]   i_adr,
   input  logic [DATA_WIDTH-1:0]   i_dat,
   output logic [DATA_WIDTH-1:0]   o_dat
);
   logic [DATA_WIDTH-1:0] r_mem [2**DEPTH_LOG2];

   always_ff @(posedge i_clk)
      if (i_en) begin
         if (i_we) begin
            for (int i = 0; i < DATA_WIDTH/8; i++)
               if (i_sel[i]) r_mem[i_adr][8*i +: 8] <= i_dat[8*i +: 8];
         end else
            o_dat <= r_mem[i_adr];
      end
endmodule

// File: rtl/wb_burst_sram.sv
// wb_burst_sram: Wishbone B4 registered-feedback burst SRAM slave with next-address prefetch
//   clk_clksys clock; reset sync active-high; wishbone_adr/dat_w/sel/we/cyc/stb/cti/bte bus
//   inputs; wishbone_dat_r read data; wishbone_ack normal and wishbone_err out-of-range termination
module wb_burst_sram
   import wb_burst_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 30,
   parameter int DEPTH_LOG2 = 10,
   parameter int SEL_WIDTH  = DATA_WIDTH/8
) (
   input  logic                  clk_clksys,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] wishbone_adr,
   input  logic [DATA_WIDTH-1:0] wishbone_dat_w,
   output logic [DATA_WIDTH-1:0] wishbone_dat_r,
   input  logic [SEL_WIDTH-1:0]  wishbone_sel,
   input  logic                  wishbone_cyc,
   input  logic                  wishbone_stb,
   input  logic                  wishbone_we,
   input  logic [2:0]            wishbone_cti,
   input  logic [1:0]            wishbone_bte,
   output logic                  wishbone_ack,
   output logic                  wishbone_err
);
   logic [ADDR_WIDTH-1:0] r_pend_adr;
   logic                  r_pend_we;
   logic                  r_valid;
   logic                  w_req, w_hit, w_oor, w_pend_oor, w_burst, w_wr, w_en;
   logic [ADDR_WIDTH-1:0] w_next;
   logic [DEPTH_LOG2-1:0] w_ram_adr;
   logic [DATA_WIDTH-1:0] w_ram_q;

   always_comb begin
      w_req      = wishbone_cyc & wishbone_stb;
      w_hit      = w_req & r_valid & (wishbone_adr == r_pend_adr) & (wishbone_we == r_pend_we);
      w_oor      = (wishbone_adr >> DEPTH_LOG2) != '0;
      w_pend_oor = (r_pend_adr >> DEPTH_LOG2) != '0;
      w_burst    = (wishbone_cti == CTI_CONST) | (wishbone_cti == CTI_INCR);
      w_next     = ADDR_WIDTH'(next_adr(64'(wishbone_adr), wishbone_cti, wishbone_bte));
      // The single port is used by the write on a write hit; write bursts never
      // consume prefetched data, so the prefetch read is skipped there.
      w_wr       = w_hit & wishbone_we & ~w_oor & ~reset;
      w_en       = w_req & ~reset & (~w_hit | w_burst | w_wr);
      w_ram_adr  = (w_hit & ~wishbone_we) ? w_next[DEPTH_LOG2-1:0] : wishbone_adr[DEPTH_LOG2-1:0];
      wishbone_ack   = w_hit & ~w_oor;
      wishbone_err   = w_hit & w_oor;
      wishbone_dat_r = (r_valid & ~w_pend_oor) ? w_ram_q : '0;
   end

   // A hit moves the prediction forward (bursts) or retires it; a miss
   // re-targets it to the presented access; stb low leaves everything held.
   always_ff @(posedge clk_clksys)
      if (reset) begin
         r_valid    <= 1'b0;
         r_pend_adr <= '0;
         r_pend_we  <= 1'b0;
      end else if (!wishbone_cyc)
         r_valid <= 1'b0;
      else if (wishbone_stb) begin
         r_valid    <= ~w_hit | w_burst;
         r_pend_adr <= w_hit ? w_next : wishbone_adr;
         r_pend_we  <= wishbone_we;
      end

   sram_1rw_be #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_ram (
      .i_clk (clk_clksys),
      .i_en  (w_en),
      .i_we  (w_wr),
      .i_sel (wishbone_sel),
      .i_adr (w_ram_adr),
      .i_dat (wishbone_dat_w),
      .o_dat (w_ram_q)
   );
endmodule

// File: tb/tb_wb_burst_sram.sv
// tb_wb_burst_sram: directed self-checking bench for wb_burst_sram
module tb_wb_burst_sram;
   import wb_burst_pkg::*;
   logic        clk = 1'b0, rst = 1'b1, cyc = 1'b0, stb = 1'b0, we = 1'b0, ack, err;
   logic [29:0] adr = '0;
   logic [31:0] dw = '0, dr;
   logic [3:0]  sel = '0;
   logic [2:0]  cti = CTI_CLASSIC;
   logic [1:0]  bte = BTE_LINEAR;
   logic [29:0] w4 [4] = '{30'h6, 30'h7, 30'h4, 30'h5};
   int          n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   wb_burst_sram dut (
      .clk_clksys     (clk),
      .reset          (rst),
      .wishbone_adr   (adr),
      .wishbone_dat_w (dw),
      .wishbone_dat_r (dr),
      .wishbone_sel   (sel),
      .wishbone_cyc   (cyc),
      .wishbone_stb   (stb),
      .wishbone_we    (we),
      .wishbone_cti   (cti),
      .wishbone_bte   (bte),
      .wishbone_ack   (ack),
      .wishbone_err   (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus(input logic c, input logic s, input logic w, input logic [29:0] a,
                      input logic [31:0] d, input logic [3:0] sl, input logic [2:0] ct,
                      input logic [1:0] bt);
      @(posedge clk);
      #1;
      cyc = c; stb = s; we = w; adr = a; dw = d; sel = sl; cti = ct; bte = bt;
      @(negedge clk);
      chk("ack_err_excl", 32'(ack & err), 32'd0);
   endtask

   task automatic beat(input logic [29:0] a, input logic w, input logic [31:0] d,
                       input logic [2:0] ct, input logic [1:0] bt);
      bus(1'b1, 1'b1, w, a, d, 4'hF, ct, bt);
   endtask

   task automatic idle();
      bus(1'b0, 1'b0, 1'b0, '0, '0, '0, CTI_CLASSIC, BTE_LINEAR);
   endtask

   task automatic term(input string tag, input logic a, input logic e);
      chk({tag, ".ack"}, 32'(ack), 32'(a));
      chk({tag, ".err"}, 32'(err), 32'(e));
   endtask

   task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] sl, input logic e);
      bus(1'b1, 1'b1, 1'b1, a, d, sl, CTI_CLASSIC, BTE_LINEAR);
      term("wr.wait", 1'b0, 1'b0);
      bus(1'b1, 1'b1, 1'b1, a, d, sl, CTI_CLASSIC, BTE_LINEAR);
      term("wr.term", ~e, e);
      idle();
   endtask

   task automatic rd(input logic [29:0] a, input logic [31:0] exp, input logic e);
      beat(a, 1'b0, '0, CTI_CLASSIC, BTE_LINEAR);
      term("rd.wait", 1'b0, 1'b0);
      beat(a, 1'b0, '0, CTI_CLASSIC, BTE_LINEAR);
      term("rd.term", ~e, e);
      chk("rd.dat", dr, exp);
      idle();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      term("reset", 1'b0, 1'b0);
      chk("reset.dat", dr, 32'd0);

      wr(30'h10, 32'hDEADBEEF, 4'hF, 1'b0);
      rd(30'h10, 32'hDEADBEEF, 1'b0);
      wr(30'h30, 32'h12345678, 4'hF, 1'b0);
      wr(30'h3FF, 32'h55AA55AA, 4'hF, 1'b0);
      wr(30'h43, 32'hCAFE0043, 4'hF, 1'b0);

      beat(30'h20, 1'b1, 32'h20, CTI_INCR, BTE_LINEAR);
      term("lwr.wait", 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         beat(30'h20 + 30'(i), 1'b1, 32'h20 + 32'(i), i == 3 ? CTI_EOB : CTI_INCR, BTE_LINEAR);
         term("lwr.beat", 1'b1, 1'b0);
      end
      idle();

      beat(30'h20, 1'b0, '0, CTI_INCR, BTE_LINEAR);
      term("lrd.wait", 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         beat(30'h20 + 30'(i), 1'b0, '0, i == 3 ? CTI_EOB : CTI_INCR, BTE_LINEAR);
         term("lrd.beat", 1'b1, 1'b0);
         chk("lrd.dat", dr, 32'h20 + 32'(i));
      end
      beat(30'h24, 1'b0, '0, CTI_INCR, BTE_LINEAR);
      term("eob.miss", 1'b0, 1'b0);
      idle();

      beat(30'h6, 1'b1, 32'h106, CTI_INCR, BTE_WRAP4);
      term("w4wr.wait", 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         beat(w4[i], 1'b1, 32'h100 + 32'(w4[i]), i == 3 ? CTI_EOB : CTI_INCR, BTE_WRAP4);
         term("w4wr.beat", 1'b1, 1'b0);
      end
      idle();
      beat(30'h6, 1'b0, '0, CTI_INCR, BTE_WRAP4);
      term("w4rd.wait", 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         beat(w4[i], 1'b0, '0, i == 3 ? CTI_EOB : CTI_INCR, BTE_WRAP4);
         term("w4rd.beat", 1'b1, 1'b0);
         chk("w4rd.dat", dr, 32'h100 + 32'(w4[i]));
      end
      idle();

      beat(30'h20, 1'b0, '0, CTI_INCR, BTE_LINEAR);
      term("stall.wait", 1'b0, 1'b0);
      beat(30'h20, 1'b0, '0, CTI_INCR, BTE_LINEAR);
      chk("stall.d20", dr, 32'h20);
      beat(30'h21, 1'b0, '0, CTI_INCR, BTE_LINEAR);
      term("stall.b21", 1'b1, 1'b0);
      repeat (2) begin
         bus(1'b1, 1'b0, 1'b0, 30'h22, '0, 4'hF, CTI_INCR, BTE_LINEAR);
         term("stall.hold", 1'b0, 1'b0);
      end
      beat(30'h22, 1'b0, '0, CTI_INCR, BTE_LINEAR);
      term("stall.resume", 1'b1, 1'b0);
      chk("stall.d22", dr, 32'h22);
      beat(30'h30, 1'b0, '0, CTI_INCR, BTE_LINEAR);
      term("mispred.miss", 1'b0, 1'b0);
      beat(30'h30, 1'b0, '0, CTI_EOB, BTE_LINEAR);
      term("mispred.ack", 1'b1, 1'b0);
      chk("mispred.dat", dr, 32'h12345678);
      idle();

      wr(30'h0, 32'h0, 4'hF, 1'b0);
      wr(30'h0, 32'hAABBCCDD, 4'b0101, 1'b0);
      rd(30'h0, 32'h00BB00DD, 1'b0);
      rd(30'h400, 32'h0, 1'b1);
      wr(30'h400, 32'hFFFFFFFF, 4'hF, 1'b1);
      rd(30'h0, 32'h00BB00DD, 1'b0);

      beat(30'h3FF, 1'b0, '0, CTI_INCR, BTE_LINEAR);
      term("top.wait", 1'b0, 1'b0);
      beat(30'h3FF, 1'b0, '0, CTI_INCR, BTE_LINEAR);
      term("top.last", 1'b1, 1'b0);
      chk("top.d3ff", dr, 32'h55AA55AA);
      beat(30'h400, 1'b0, '0, CTI_INCR, BTE_LINEAR);
      term("top.oor0", 1'b0, 1'b1);
      chk("top.door0", dr, 32'h0);
      beat(30'h401, 1'b0, '0, CTI_EOB, BTE_LINEAR);
      term("top.oor1", 1'b0, 1'b1);
      idle();

      beat(30'h42, 1'b1, 32'hB0, CTI_INCR, BTE_WRAP8);
      term("rst.wait", 1'b0, 1'b0);
      beat(30'h42, 1'b1, 32'hB0, CTI_INCR, BTE_WRAP8);
      term("rst.beat1", 1'b1, 1'b0);
      beat(30'h43, 1'b1, 32'hB1, CTI_INCR, BTE_WRAP8);
      rst = 1'b1;
      beat(30'h44, 1'b1, 32'hB2, CTI_INCR, BTE_WRAP8);
      term("rst.after", 1'b0, 1'b0);
      rst = 1'b0;
      beat(30'h44, 1'b1, 32'hB2, CTI_EOB, BTE_WRAP8);
      term("rst.resume", 1'b1, 1'b0);
      idle();
      rd(30'h43, 32'hCAFE0043, 1'b0);
      rd(30'h42, 32'hB0, 1'b0);
      rd(30'h44, 32'hB2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
